// File: rtl/mips_cpu_alu_mdu_if.sv
// mips_cpu_alu_mdu_if
//   Bundles the execute-unit request/response handshake for mips_cpu_alu_mdu.
//   Request side : in_valid, in_ready, op, a, b, sa
//   Response side: out_valid, out_ready, result, zero
//   Status       : hi, lo (architectural HI/LO), busy (multiply/divide iterating)
//   master = controller side, slave = execute unit.
interface mips_cpu_alu_mdu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   sa;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output in_valid, op, a, b, sa, out_ready,
    input  in_ready, out_valid, result, zero, hi, lo, busy
  );

  modport slave (
    input  in_valid, op, a, b, sa, out_ready,
    output in_ready, out_valid, result, zero, hi, lo, busy
  );
endinterface

// File: rtl/mips_cpu_alu_mdu.sv
// mips_cpu_alu_mdu
//   Multi-cycle execute unit: single-cycle integer ALU ops plus an iterative
//   shift-add multiplier and restoring divider that write HI/LO.
//   Ports: clk (rising edge), reset (async, active-high), bus (slave modport of
//   mips_cpu_alu_mdu_if: request op/a/b/sa with in_valid/in_ready, response
//   result/zero with out_valid/out_ready, plus hi, lo, busy).
//   Build option: define MIPS_CPU_MDU_DIV_EN to include the divider (ops 15/16);
//   otherwise those opcodes behave as undefined 1-cycle ops.
module mips_cpu_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mips_cpu_alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_next;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   result_r, hi_r, lo_r;
  logic               zero_r;

  logic               accept, mdu_op, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, alu_res;

  logic [2*WIDTH-1:0] acc, mdu_step, mul_step, prod;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
`ifdef MIPS_CPU_MDU_DIV_EN
  logic               is_div, neg_rem, div_zero;
  logic [WIDTH-1:0]   a_keep, quo, rem;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_step;
`endif

  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [4:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b,
    input logic [SHW-1:0]   f_sa,
    input logic [WIDTH-1:0] f_hi,
    input logic [WIDTH-1:0] f_lo
  );
    logic signed [WIDTH-1:0] s_a, s_b;
    logic [WIDTH-1:0]        r;
    s_a = f_a;
    s_b = f_b;
    case (f_op)
      5'd0:    r = f_a & f_b;
      5'd1:    r = f_a | f_b;
      5'd2:    r = f_a + f_b;
      5'd3:    r = f_a - f_b;
      5'd4:    r = {{(WIDTH-1){1'b0}}, (s_a < s_b)};
      5'd5:    r = f_a ^ f_b;
      5'd6:    r = f_b << f_sa;
      5'd7:    r = f_b >> f_sa;
      5'd8:    r = s_b >>> f_sa;
      5'd9:    r = f_b << f_a[SHW-1:0];
      5'd10:   r = f_b >> f_a[SHW-1:0];
      5'd11:   r = s_b >>> f_a[SHW-1:0];
      5'd12:   r = {{(WIDTH-1){1'b0}}, (f_a < f_b)};
      5'd17,
      5'd18:   r = f_a;
      5'd19:   r = f_hi;
      5'd20:   r = f_lo;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Request decode: operand magnitudes feed the unsigned iterative core.
  always_comb begin
    accept    = bus.in_valid && (state == IDLE);
    mdu_op    = (bus.op == 5'd13) || (bus.op == 5'd14);
    signed_op = (bus.op == 5'd13);
`ifdef MIPS_CPU_MDU_DIV_EN
    mdu_op    = mdu_op || (bus.op == 5'd15) || (bus.op == 5'd16);
    signed_op = signed_op || (bus.op == 5'd15);
`endif
    a_neg     = signed_op && bus.a[WIDTH-1];
    b_neg     = signed_op && bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    alu_res   = alu_eval(bus.op, bus.a, bus.b, bus.sa, hi_r, lo_r);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = mdu_op ? BUSY : DONE;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc[WIDTH-1:1]};
    mdu_step = mul_step;
    prod     = neg_res ? -mul_step : mul_step;
    fin_hi   = prod[2*WIDTH-1:WIDTH];
    fin_lo   = prod[WIDTH-1:0];
`ifdef MIPS_CPU_MDU_DIV_EN
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // A borrow means the trial subtraction failed: restore and shift in 0.
    div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quo       = div_step[WIDTH-1:0];
    rem       = div_step[2*WIDTH-1:WIDTH];
    if (is_div) begin
      mdu_step = div_step;
      fin_lo   = div_zero ? '1     : (neg_res ? -quo : quo);
      fin_hi   = div_zero ? a_keep : (neg_rem ? -rem : rem);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Architectural results: written at accept for ALU ops, at the last step for mult/div.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      result_r <= '0;
      zero_r   <= 1'b1;
      hi_r     <= '0;
      lo_r     <= '0;
    end else if (accept) begin
      if (mdu_op) begin
        cnt <= SHW'(WIDTH-1);
      end else begin
        result_r <= alu_res;
        zero_r   <= (alu_res == '0);
        if (bus.op == 5'd17) hi_r <= bus.a;
        if (bus.op == 5'd18) lo_r <= bus.a;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        hi_r     <= fin_hi;
        lo_r     <= fin_lo;
        result_r <= fin_lo;
        zero_r   <= (fin_lo == '0);
      end
    end
  end

  // Iteration datapath: loaded at accept, stepped while BUSY.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc     <= {{WIDTH{1'b0}}, a_mag};
      opnd    <= b_mag;
      neg_res <= a_neg ^ b_neg;
`ifdef MIPS_CPU_MDU_DIV_EN
      is_div   <= (bus.op == 5'd15) || (bus.op == 5'd16);
      neg_rem  <= a_neg;
      div_zero <= (bus.b == '0);
      a_keep   <= bus.a;
`endif
    end else if (state == BUSY) begin
      acc <= mdu_step;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == BUSY);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
endmodule

// File: tb/tb_mips_cpu_alu_mdu.sv
// tb_mips_cpu_alu_mdu
//   Self-checking bench for mips_cpu_alu_mdu (WIDTH=32): directed corner cases,
//   reset during a multiply, backpressure, then randomized ops against a
//   behavioural model of the architectural result and HI/LO.
module tb_mips_cpu_alu_mdu;
  localparam int WIDTH = 32;
  localparam int SHW   = $clog2(WIDTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_alu_mdu_if #(.WIDTH(WIDTH)) bus();

  mips_cpu_alu_mdu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] e_res, e_hi, e_lo;
  int          e_lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: evaluated at the accept edge with HI/LO as they stand then.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [SHW-1:0] sa);
    logic [63:0] p;
    longint      a64, b64;
    int          qa, qb;
    e_lat = 1;
    e_res = '0;
    case (op)
      5'd0:  e_res = a & b;
      5'd1:  e_res = a | b;
      5'd2:  e_res = a + b;
      5'd3:  e_res = a - b;
      5'd4:  e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5:  e_res = a ^ b;
      5'd6:  e_res = b << sa;
      5'd7:  e_res = b >> sa;
      5'd8:  e_res = $signed(b) >>> sa;
      5'd9:  e_res = b << a[4:0];
      5'd10: e_res = b >> a[4:0];
      5'd11: e_res = $signed(b) >>> a[4:0];
      5'd12: e_res = (a < b) ? 32'd1 : 32'd0;
      5'd13, 5'd14: begin
        if (op == 5'd13) begin
          a64 = $signed(a);
          b64 = $signed(b);
          p   = a64 * b64;
        end else begin
          p = {32'b0, a} * {32'b0, b};
        end
        m_hi  = p[63:32];
        m_lo  = p[31:0];
        e_res = m_lo;
        e_lat = WIDTH + 1;
      end
`ifdef MIPS_CPU_MDU_DIV_EN
      5'd15, 5'd16: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 5'd16) begin
          m_lo = a / b;
          m_hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          qa   = a;
          qb   = b;
          m_lo = qa / qb;
          m_hi = qa % qb;
        end
        e_res = m_lo;
        e_lat = WIDTH + 1;
      end
`endif
      5'd17: begin m_hi = a; e_res = a; end
      5'd18: begin m_lo = a; e_res = a; end
      5'd19: e_res = m_hi;
      5'd20: e_res = m_lo;
      default: e_res = '0;
    endcase
    e_hi = m_hi;
    e_lo = m_lo;
  endtask

  // Present a request, wait for its accept edge, then scramble the inputs.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [SHW-1:0] sa);
    int k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.sa       = sa;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("accept_wait", 32'(k < 200), 32'd1);
    @(posedge clk);
    model(op, a, b, sa);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 5'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.sa       = SHW'($urandom);
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("release", 32'(bus.out_valid), 32'd0);
  endtask

  // Called right after issue(): measures latency, checks outputs, optional backpressure.
  task automatic collect(input string tag, input int hold);
    int lat = 1;
    bus.out_ready = (hold == 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'(e_lat > 1));
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, e_lat);
    check_eq({tag, "_res"}, bus.result, e_res);
    check_eq({tag, "_zero"}, 32'(bus.zero), 32'(e_res == 32'd0));
    check_eq({tag, "_hi"}, bus.hi, e_hi);
    check_eq({tag, "_lo"}, bus.lo, e_lo);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_res"}, bus.result, e_res);
      check_eq({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    consume();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sa        = '0;
    bus.out_ready = 1'b0;
    m_hi          = '0;
    m_lo          = '0;
    #12;
    check_eq("rst_res", bus.result, 32'd0);
    check_eq("rst_zero", 32'(bus.zero), 32'd1);
    check_eq("rst_hi", bus.hi, 32'd0);
    check_eq("rst_lo", bus.lo, 32'd0);
    check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    issue(5'd2,  32'hFFFF_FFFF, 32'd1, 5'd0);          collect("add_wrap", 0);
    issue(5'd4,  32'hFFFF_FFFF, 32'd1, 5'd0);          collect("slt", 0);
    issue(5'd12, 32'hFFFF_FFFF, 32'd1, 5'd0);          collect("sltu", 1);
    issue(5'd11, 32'd36, 32'h8000_0000, 5'd0);         collect("srav", 0);
    issue(5'd7,  32'd0, 32'h8000_0000, 5'd31);         collect("srl31", 0);
    issue(5'd13, 32'hFFFF_FFFD, 32'd7, 5'd0);          collect("mult", 0);
    issue(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);  collect("multu", 2);
    issue(5'd15, 32'hFFFF_FFF9, 32'd2, 5'd0);          collect("div", 0);
    issue(5'd16, 32'd5, 32'd0, 5'd0);                  collect("divu0", 0);
    issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);  collect("divmin", 0);
    issue(5'd17, 32'h1234_5678, 32'd0, 5'd0);          collect("mthi", 0);
    issue(5'd18, 32'h9ABC_DEF0, 32'd0, 5'd0);          collect("mtlo", 0);
    issue(5'd19, 32'd0, 32'd0, 5'd0);                  collect("mfhi", 0);
    issue(5'd20, 32'd0, 32'd0, 5'd0);                  collect("mflo", 0);
    issue(5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);  collect("undef", 0);

    // Reset in the middle of a multiply aborts it and clears HI/LO at once.
    issue(5'd14, 32'h0001_0003, 32'h0007_0005, 5'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mrst_vld", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_busy", 32'(bus.busy), 32'd0);
    check_eq("mrst_hi", bus.hi, 32'd0);
    check_eq("mrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    issue(5'd1, 32'h00F0_0000, 32'h0000_000F, 5'd0);   collect("post_rst", 0);

    // Backpressure with the next request waiting the whole time.
    issue(5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 5'd2;
    bus.a         = 32'd10;
    bus.b         = 32'd20;
    bus.sa        = '0;
    check_eq("bp_vld0", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_eq("bp_res", bus.result, e_res);
      check_eq("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("bp_idle_rdy", 32'(bus.in_ready), 32'd1);
    check_eq("bp_idle_vld", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    model(5'd2, 32'd10, 32'd20, '0);
    #1;
    bus.in_valid = 1'b0;
    check_eq("bp_next_vld", 32'(bus.out_valid), 32'd1);
    check_eq("bp_next_res", bus.result, e_res);
    consume();

    for (int i = 0; i < 150; i++) begin
      r_op = ($urandom_range(0, 9) < 4) ? 5'(13 + $urandom_range(0, 3))
                                        : 5'($urandom_range(0, 31));
      r_a  = pick();
      r_b  = pick();
      issue(r_op, r_a, r_b, SHW'($urandom));
      collect($sformatf("rnd%0d_op%0d", i, r_op), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
